demux_collect8: RTL
===================

// Module: demux_collect8
// PURPOSE
//   Sequential inverse of the 8:1 bit-select mux.
//   - Accepts one bit per transfer, tagged with a select index, and steers it into bit position sel.
//   - Once every position has been written, presents the assembled word on a valid/ready output port.
//   - Sits on the receive side of a link that serialises a word through a bit-select mux, in any order.
// PARAMETERS
//   WIDTH   8               number of bit positions / output word width
//   SEL_W   $clog2(WIDTH)   select index width (3 at default)
// PORTS
//   clk        input   1        rising-edge clock, single clock domain
//   rst        input   1        asynchronous, active-high reset
//   in_bit     input   1        data bit to steer
//   in_sel     input   SEL_W    destination bit position
//   in_valid   input   1        in_bit/in_sel valid this cycle
//   in_ready   output  1        block can accept a bit
//   flush      input   1        synchronous abort of the partial word / pending output
//   out_data   output  WIDTH    assembled word
//   out_valid  output  1        out_data complete and stable
//   out_ready  input   1        consumer accepts out_data
//   fill_cnt   output  SEL_W+1  number of distinct positions written so far
//   err        output  1        one-cycle pulse: duplicate or out-of-range select
// BEHAVIOUR
//   Reset (async, rst=1)
//     - state=COLLECT; data_reg=0, mask=0; out_data=0, out_valid=0, fill_cnt=0, err=0.
//     - in_ready=1 as soon as rst deasserts.
//   Accept rule: a transfer happens on a clk edge with in_valid & in_ready.
//   State COLLECT (in_ready=1, out_valid=0)
//     - On accept with in_sel<WIDTH:
//       - data_reg[in_sel] <= in_bit; mask[in_sel] <= 1.
//       - If mask[in_sel] was already 1: the bit is overwritten, err=1 for exactly the next cycle, and fill_cnt is unchanged.
//       - Otherwise fill_cnt increments.
//     - On accept with in_sel>=WIDTH (only possible when WIDTH is not a power of 2): bit is dropped, err pulses, nothing else changes.
//     - If the accept completes the mask (all ones):
//       - next cycle out_data = full word including this bit, out_valid=1, state=FULL.
//       - mask, data_reg and fill_cnt are cleared in the same edge.
//     - Latency: out_valid rises exactly 1 cycle after the final accepted bit.
//   State FULL (in_ready=0, out_valid=1)
//     - out_data is held stable; in_valid is ignored (no accept).
//     - On out_valid & out_ready: out_valid=0 and state=COLLECT next cycle; out_data keeps its last value.
//     - A new bit can be accepted no earlier than the cycle after the output handshake (no same-cycle overlap).
//   flush (synchronous, highest priority after reset)
//     - In COLLECT: mask, data_reg and fill_cnt clear; any same-cycle accept is discarded (no err).
//     - In FULL: the pending word is dropped; out_valid=0 and state=COLLECT next cycle.
//   Ordering: bits may arrive in any order; only set coverage of positions matters.
//   err never asserts for two consecutive cycles from a single transfer.
// TESTING
//   1. In-order fill: sel 0..7, bits 1,0,1,1,0,0,1,0, out_ready=1
//      -> out_data=8'h4D, out_valid for 1 cycle, 1 cycle after the 8th accept; fill_cnt 1..7, then 0.
//   2. Reverse fill: sel 7..0 with the same bit-per-position values -> out_data=8'h4D; err stays 0.
//   3. Duplicate: sel=3 with bit 1, later sel=3 with bit 0, then the remaining positions
//      -> err pulses once; fill_cnt does not advance on the duplicate; final bit3=0.
//   4. Backpressure: complete a word and hold out_ready=0 for 5 cycles while driving in_valid=1
//      -> in_ready=0, no accepts, out_data stable; after out_ready=1, in_ready returns the next cycle.
//   5. Flush: write 5 bits, pulse flush together with an in_valid
//      -> fill_cnt=0, no err; a following clean 8-bit sequence yields exactly the new word.
//   6. Async reset: assert rst mid-collect (fill_cnt=4) and again in FULL, off-edge
//      -> all outputs reach their reset values immediately, without a clock edge.

Source files
------------

// File: rtl/demux_collect8.sv
// Steers one tagged bit per transfer into position in_sel and emits the word once every position is written.
// Latency: out_valid rises one cycle after the accept that completes the word.
// Backpressure: in_ready is low while a full word waits for out_ready; flush drops partial or pending words.
module demux_collect8 #(
    parameter int WIDTH = 8,
    parameter int SEL_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_bit,
    input  logic [SEL_W-1:0] in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SEL_W:0]   fill_cnt,
    output logic             err
);
    typedef enum logic {COLLECT, FULL} state_t;

    state_t           state;
    logic [WIDTH-1:0] data_reg;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] sel_oh;
    logic [WIDTH-1:0] data_nxt;
    logic [WIDTH-1:0] mask_nxt;
    logic             in_range;
    logic             accept;
    logic             dup;

    assign in_ready = (state == COLLECT);
    assign accept   = in_valid & in_ready;

    always_comb begin
        in_range = ({1'b0, in_sel} < (SEL_W+1)'(WIDTH));
        sel_oh   = '0;
        if (in_range) sel_oh[in_sel] = 1'b1;
        dup      = |(mask & sel_oh);
        mask_nxt = mask | sel_oh;
        data_nxt = (data_reg & ~sel_oh) | (in_bit ? sel_oh : '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= COLLECT;
            data_reg  <= '0;
            mask      <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            fill_cnt  <= '0;
            err       <= 1'b0;
        end else begin
            err <= 1'b0;
            if (flush) begin
                // out_data is left alone so a dropped word never glitches the data bus
                state     <= COLLECT;
                out_valid <= 1'b0;
                data_reg  <= '0;
                mask      <= '0;
                fill_cnt  <= '0;
            end else begin
                case (state)
                    COLLECT: begin
                        if (accept) begin
                            if (!in_range) begin
                                err <= 1'b1;
                            end else if (&mask_nxt) begin
                                // a duplicate can never complete the mask, so no err here
                                out_data  <= data_nxt;
                                out_valid <= 1'b1;
                                state     <= FULL;
                                data_reg  <= '0;
                                mask      <= '0;
                                fill_cnt  <= '0;
                            end else begin
                                data_reg <= data_nxt;
                                mask     <= mask_nxt;
                                if (dup) err <= 1'b1;
                                else     fill_cnt <= fill_cnt + (SEL_W+1)'(1);
                            end
                        end
                    end
                    FULL: begin
                        if (out_ready) begin
                            out_valid <= 1'b0;
                            state     <= COLLECT;
                        end
                    end
                    default: state <= COLLECT;
                endcase
            end
        end
    end
endmodule
